// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative chunked multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, MULT, NEG} mult_state_t;

  // Widest operand the helper below can scan.
  localparam int MAX_W = 256;

  // Index of the highest nonzero d-bit chunk within the low w bits of v.
  // Returns 0 when v is zero, so the multiplier still runs one pass.
  function automatic int lead_chunk(input logic [MAX_W-1:0] v, input int w, input int d);
    int k;
    k = 0;
    for (int bi = 0; bi < w; bi++) begin
      if (v[bi]) k = bi / d;
    end
    return k;
  endfunction

endpackage

// File: rtl/mult_iter_param_arith.sv
// Datapath of the iterative multiplier: operand magnitudes, chunk selection,
// DxD chunk multiply, positional shift, 2W accumulator and final negate.
module mult_iter_param_arith
  import mult_pkg::*;
#(
  parameter int W = 32,
  parameter int D = 8,
  localparam int N = W / D,
  localparam int KW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            upd,
  input  logic            neg_en,
  input  logic            signed_mode,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [KW-1:0]   sel_i,
  input  logic [KW-1:0]   sel_j,
  output logic [KW-1:0]   ka,
  output logic [KW-1:0]   kb,
  output logic            neg,
  output logic            acc_next_nz,
  output logic [2*W-1:0]  product
);

  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic [W-1:0]    in_mag_a;
  logic [W-1:0]    in_mag_b;
  logic [KW-1:0]   in_ka;
  logic [KW-1:0]   in_kb;
  logic [D-1:0]    chunk_a;
  logic [D-1:0]    chunk_b;
  logic [2*D-1:0]  chunk_prod;
  logic [2*W-1:0]  term;
  logic [2*W-1:0]  acc_next;

  // Magnitudes of the incoming operands; the most negative value wraps to
  // 2^(W-1), which is its correct unsigned magnitude.
  always_comb begin
    in_mag_a = (signed_mode && a[W-1]) ? -a : a;
    in_mag_b = (signed_mode && b[W-1]) ? -b : b;
    in_ka    = KW'(lead_chunk(MAX_W'(in_mag_a), W, D));
    in_kb    = KW'(lead_chunk(MAX_W'(in_mag_b), W, D));
  end

  // Capture magnitudes, leading-chunk indices and result sign on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_a <= '0;
      mag_b <= '0;
      ka    <= '0;
      kb    <= '0;
      neg   <= 1'b0;
    end else if (clr) begin
      mag_a <= in_mag_a;
      mag_b <= in_mag_b;
      ka    <= in_ka;
      kb    <= in_kb;
      neg   <= signed_mode & (a[W-1] ^ b[W-1]);
    end
  end

  // One chunk pair product, shifted to its weight D*(i+j) and added in.
  always_comb begin
    chunk_a     = mag_a[int'(sel_i) * D +: D];
    chunk_b     = mag_b[int'(sel_j) * D +: D];
    chunk_prod  = chunk_a * chunk_b;
    term        = (2 * W)'(chunk_prod) << (D * (int'(sel_i) + int'(sel_j)));
    acc_next    = product + term;
    acc_next_nz = |acc_next;
  end

  // Accumulator: cleared on start, summed during MULT, negated once in NEG.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product <= '0;
    end else if (clr) begin
      product <= '0;
    end else if (upd) begin
      product <= acc_next;
    end else if (neg_en) begin
      product <= -product;
    end
  end

endmodule

// File: rtl/mult_iter_param.sv
// Iterative WxW multiplier (signed or unsigned per operation) that walks
// D-bit chunk pairs, skipping all-zero leading chunks of either operand.
module mult_iter_param
  import mult_pkg::*;
#(
  parameter int W = 32,
  parameter int D = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic            busy,
  output logic            done,
  output logic [2*W-1:0]  product
);

  localparam int N  = W / D;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  if (W % D != 0) begin : g_width_check
    $error("mult_iter_param: W must be a multiple of D");
  end

  mult_state_t    state;
  mult_state_t    state_next;
  logic [KW-1:0]  i;
  logic [KW-1:0]  j;
  logic [KW-1:0]  ka;
  logic [KW-1:0]  kb;
  logic           neg;
  logic           acc_next_nz;
  logic           clr;
  logic           upd;
  logic           neg_en;
  logic           last;

  mult_iter_param_arith #(.W(W), .D(D)) u_arith (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .upd         (upd),
    .neg_en      (neg_en),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .sel_i       (i),
    .sel_j       (j),
    .ka          (ka),
    .kb          (kb),
    .neg         (neg),
    .acc_next_nz (acc_next_nz),
    .product     (product)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_next = state;
    clr        = 1'b0;
    upd        = 1'b0;
    neg_en     = 1'b0;
    last       = (i == ka) && (j == kb);
    unique case (state)
      IDLE: begin
        if (start) begin
          clr        = 1'b1;
          state_next = MULT;
        end
      end
      MULT: begin
        upd = 1'b1;
        if (last) state_next = (neg && acc_next_nz) ? NEG : IDLE;
      end
      NEG: begin
        neg_en     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Chunk counters: i runs fastest over 0..ka, j steps once per i wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i <= '0;
      j <= '0;
    end else if (clr) begin
      i <= '0;
      j <= '0;
    end else if (upd) begin
      if (i == ka) begin
        i <= '0;
        j <= j + KW'(1);
      end else begin
        i <= i + KW'(1);
      end
    end
  end

  // Done pulses in the first IDLE cycle after an operation completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (state != IDLE) && (state_next == IDLE);
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_iter_param.sv
// Directed and randomised checks of mult_iter_param with W=32, D=8.
module tb_mult_iter_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  mult_iter_param #(.W(32), .D(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Counts busy cycles from the current sample point until busy drops.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
    end
  endtask

  // Starts one operation and checks latency, done pulse width and result.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sm,
                        input logic [63:0] exp, input int expl, input string tag);
    int cnt;
    a = x; b = y; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(cnt);
    chk({tag, " latency"}, 64'(cnt), 64'(expl));
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " product"}, product, exp);
    @(posedge clk); #1;
    chk({tag, " done width"}, 64'(done), 64'd0);
    chk({tag, " product hold"}, product, exp);
  endtask

  function automatic int kidx(input logic [31:0] v);
    int k;
    k = 0;
    for (int c = 0; c < 4; c++) if (v[c*8 +: 8] != 8'd0) k = c;
    return k;
  endfunction

  function automatic logic [31:0] magn(input logic [31:0] v, input logic sm);
    return (sm && v[31]) ? -v : v;
  endfunction

  function automatic logic [31:0] pattern(input int sel);
    logic [31:0] v;
    v = $urandom;
    case (sel)
      0: ;
      1: begin
        for (int c = 0; c < 4; c++) if ($urandom_range(0, 1) == 0) v[c*8 +: 8] = 8'd0;
      end
      2: v = v & 32'h0000_00FF;
      default: begin
        case ($urandom_range(0, 4))
          0: v = 32'h0000_0000;
          1: v = 32'h8000_0000;
          2: v = 32'hFFFF_FFFF;
          3: v = 32'h0000_0001;
          default: v = 32'h0100_0000;
        endcase
      end
    endcase
    return v;
  endfunction

  initial begin
    int cnt;
    logic seen_done;
    logic [31:0] x, y;
    logic sm;
    logic [63:0] exp;
    logic signed [63:0] px, py;
    int lat;

    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset product", product, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(32'd5, 32'd7, 1'b0, 64'd35, 1, "t1 unsigned small");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 16, "t2 unsigned max");
    run_op(32'hFFFF_FFFD, 32'h0000_0100, 1'b1, 64'hFFFF_FFFF_FFFF_FD00, 3, "t3 signed neg");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 16, "t4 signed min");
    run_op(32'd0, 32'h1234_5678, 1'b0, 64'd0, 4, "t5 zero a");
    run_op(32'hFFFF_FFFF, 32'd0, 1'b1, 64'd0, 1, "signed -1 times 0");

    // Start pulse while busy must be ignored.
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    cnt = 0;
    while (busy && cnt < 200) begin
      if (cnt == 3) begin
        start = 1'b1; a = 32'd1; b = 32'd1; signed_mode = 1'b1;
      end else begin
        start = 1'b0;
      end
      cnt++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy start latency", 64'(cnt), 64'd16);
    chk("busy start done", 64'(done), 64'd1);
    chk("busy start product", product, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk); #1;
    chk("busy start no restart", 64'(busy), 64'd0);

    // Start accepted in the done cycle clears the product on that edge.
    a = 32'd5; b = 32'd7; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b done", 64'(done), 64'd1);
    chk("b2b first product", product, 64'd35);
    a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b product cleared", product, 64'd0);
    chk("b2b busy", 64'(busy), 64'd1);
    chk("b2b done dropped", 64'(done), 64'd0);
    wait_idle(cnt);
    chk("b2b second latency", 64'(cnt), 64'd1);
    chk("b2b second product", product, 64'd6);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a long operation.
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("mid busy before reset", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset product", product, 64'd0);
    chk("async reset done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    chk("no done after abort", 64'(seen_done), 64'd0);
    run_op(32'd2, 32'd3, 1'b0, 64'd6, 1, "t6 after reset");

    // Random operands against a reference product and latency model.
    for (int n = 0; n < 300; n++) begin
      x  = pattern($urandom_range(0, 3));
      y  = pattern($urandom_range(0, 3));
      sm = 1'($urandom_range(0, 1));
      if (sm) begin
        px  = {{32{x[31]}}, x};
        py  = {{32{y[31]}}, y};
        exp = px * py;
      end else begin
        exp = {32'd0, x} * {32'd0, y};
      end
      lat = (kidx(magn(x, sm)) + 1) * (kidx(magn(y, sm)) + 1);
      if (sm && (x[31] ^ y[31]) && exp != 64'd0) lat = lat + 1;
      run_op(x, y, sm, exp, lat, $sformatf("rand%0d %h*%h s%0d", n, x, y, sm));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
